irq_controller: RTL and testbench

//  Prioritising interrupt controller between the peripheral interrupt sources and the

---
 rtl/irq_ctrl_pkg.sv | 35 +++
 rtl/irq_controller_if.sv | 20 ++
 rtl/irq_capture.sv | 30 +++
 rtl/irq_controller.sv | 128 ++++++++++++
 tb/tb_irq_controller.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the prioritising interrupt controller:
// FSM encoding, default port ids, status field positions and the priority encoder.
package irq_ctrl_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam logic [15:0] MASK_ID_DEF = 16'h0030;
  localparam logic [15:0] PEND_ID_DEF = 16'h0031;
  localparam logic [15:0] CFG_ID_DEF  = 16'h0032;

  localparam int ST_MASK_LSB = 0;
  localparam int ST_PEND_LSB = 4;
  localparam int ST_MODE_LSB = 8;
  localparam int ST_CUR_LSB  = 13;
  localparam int ST_BUSY_BIT = 15;

  localparam logic [15:0] STATUS_RST = 16'h0F00;

  // Lowest set index wins; index 0 is the highest priority.
  function automatic logic [1:0] prio_enc(input logic [NUM_SRC-1:0] req);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Processor port bus plus interrupt source/ack/request lines of the controller.
interface irq_controller_if;
  logic        write;
  logic [15:0] id;
  logic [15:0] din;
  logic [3:0]  irq_src;
  logic [3:0]  irq_ack;
  logic [3:0]  irq_out;
  logic [15:0] status;

  modport master (
    output write, id, din, irq_src, irq_ack,
    input  irq_out, status
  );

  modport slave (
    input  write, id, din, irq_src, irq_ack,
    output irq_out, status
  );
endinterface

// File: rtl/irq_capture.sv
// Per-source capture: two-flop synchroniser, previous-value flop and
// edge/level selection producing a one-cycle (edge) or held (level) set request.
module irq_capture (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,
  output logic set_req
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Stage p0/p1: synchronise the asynchronous source; p2: previous value for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= src;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign set_req = mode ? (sync_p1 & ~prev_p2) : sync_p1;

endmodule

// File: rtl/irq_controller.sv
// Prioritising interrupt controller: mask/mode/pending registers, priority
// selection, one-at-a-time presentation FSM with ack retire and post-retire gap.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter logic [15:0] MASK_ID    = MASK_ID_DEF,
  parameter logic [15:0] PEND_ID    = PEND_ID_DEF,
  parameter logic [15:0] CFG_ID     = CFG_ID_DEF,
  parameter int          GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  irq_controller_if.slave  bus
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  state_t              state, state_nxt;
  logic [1:0]          cur, cur_nxt;
  logic [3:0]          gap_cnt, gap_nxt;
  logic [NUM_SRC-1:0]  irq_q, irq_nxt;
  logic [NUM_SRC-1:0]  mask, mode, pending, pending_nxt;
  logic [NUM_SRC-1:0]  set_req, clr;
  logic [15:0]         status_q, status_nxt;
  logic                mask_wr, pend_wr, cfg_wr, retire;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cap
    irq_capture u_cap (
      .clk     (clk),
      .reset   (reset),
      .src     (bus.irq_src[g]),
      .mode    (mode[g]),
      .set_req (set_req[g])
    );
  end

  assign mask_wr = bus.write && (bus.id == MASK_ID);
  assign pend_wr = bus.write && (bus.id == PEND_ID);
  assign cfg_wr  = bus.write && (bus.id == CFG_ID);

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    gap_nxt   = gap_cnt;
    irq_nxt   = irq_q;
    retire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pending & mask) != '0) begin
          cur_nxt   = prio_enc(pending & mask);
          irq_nxt   = 4'b0001 << cur_nxt;
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // Ack has priority over an abort seen in the same cycle.
        if (bus.irq_ack[cur]) begin
          retire    = 1'b1;
          irq_nxt   = '0;
          gap_nxt   = GAP_LOAD;
          state_nxt = ST_GAP;
        end else if (!mask[cur] || !pending[cur]) begin
          irq_nxt   = '0;
          gap_nxt   = GAP_LOAD;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= 4'd1) begin
          gap_nxt   = '0;
          cur_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = gap_cnt - 4'd1;
        end
      end
      default: begin
        irq_nxt   = '0;
        cur_nxt   = '0;
        gap_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // A set request in the same cycle as a clear wins so no event is lost.
  always_comb begin
    clr = '0;
    if (retire) clr[cur] = 1'b1;
    if (pend_wr) clr = clr | bus.din[NUM_SRC-1:0];
    pending_nxt = (pending & ~clr) | set_req;
  end

  always_comb begin
    status_nxt                           = '0;
    status_nxt[ST_BUSY_BIT]              = (state != ST_IDLE);
    status_nxt[ST_CUR_LSB +: 2]          = cur;
    status_nxt[ST_MODE_LSB +: NUM_SRC]   = mode;
    status_nxt[ST_PEND_LSB +: NUM_SRC]   = pending;
    status_nxt[ST_MASK_LSB +: NUM_SRC]   = mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur      <= '0;
      gap_cnt  <= '0;
      irq_q    <= '0;
      mask     <= '0;
      mode     <= '1;
      pending  <= '0;
      status_q <= STATUS_RST;
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      gap_cnt  <= gap_nxt;
      irq_q    <= irq_nxt;
      pending  <= pending_nxt;
      status_q <= status_nxt;
      if (mask_wr) mask <= bus.din[NUM_SRC-1:0];
      if (cfg_wr)  mode <= bus.din[NUM_SRC-1:0];
    end
  end

  assign bus.irq_out = irq_q;
  assign bus.status  = status_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomised and scenario-driven bench for irq_controller with a scoreboard
// fed by a behavioural model of the controller's rules.
module tb_irq_controller;

  localparam int          GAP     = 1;
  localparam logic [15:0] MASK_ID = 16'h0030;
  localparam logic [15:0] PEND_ID = 16'h0031;
  localparam logic [15:0] CFG_ID  = 16'h0032;

  logic clk = 1'b0;
  logic reset;

  irq_controller_if bus ();

  irq_controller #(
    .MASK_ID    (MASK_ID),
    .PEND_ID    (PEND_ID),
    .CFG_ID     (CFG_ID),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  irq;
    logic [15:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // Behavioural model state
  logic [3:0]  m_mask, m_mode, m_pend;
  logic [15:0] m_status;
  int          m_pres;   // index being presented, -1 if none
  int          m_cur;    // last presented index, shown while busy
  int          m_gap;    // gap cycles remaining
  logic [3:0]  hist [4]; // hist[k] = irq_src driven k cycles ago

  task automatic model_reset();
    m_mask = 4'h0; m_mode = 4'hF; m_pend = 4'h0; m_status = 16'h0F00;
    m_pres = -1; m_cur = 0; m_gap = 0;
    for (int k = 0; k < 4; k++) hist[k] = 4'h0;
  endtask

  task automatic model_step(input logic r, input logic w, input logic [15:0] i,
                            input logic [15:0] d, input logic [3:0] s, input logic [3:0] a,
                            output logic [3:0] e_irq, output logic [15:0] e_st);
    logic [3:0] sreq, clr;
    logic       busy;
    logic [1:0] shown;
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = s;
    if (r) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++)
        sreq[k] = m_mode[k] ? (hist[2][k] & ~hist[3][k]) : hist[2][k];
      busy     = (m_pres >= 0) || (m_gap > 0);
      shown    = busy ? 2'(m_cur) : 2'd0;
      m_status = {busy, shown, 1'b0, m_mode, m_pend, m_mask};
      clr = (w && i == PEND_ID) ? d[3:0] : 4'h0;
      if (m_gap > 0) begin
        m_gap = m_gap - 1;
      end else if (m_pres < 0) begin
        for (int k = 3; k >= 0; k--)
          if (m_pend[k] && m_mask[k]) m_pres = k;
        if (m_pres >= 0) m_cur = m_pres;
      end else if (a[m_pres]) begin
        clr[m_pres] = 1'b1;
        m_pres = -1;
        m_gap  = GAP;
      end else if (!m_mask[m_pres] || !m_pend[m_pres]) begin
        m_pres = -1;
        m_gap  = GAP;
      end
      if (w && i == MASK_ID) m_mask = d[3:0];
      if (w && i == CFG_ID)  m_mode = d[3:0];
      m_pend = (m_pend & ~clr) | sreq;
    end
    e_irq = (m_pres >= 0) ? (4'b0001 << m_pres) : 4'b0000;
    e_st  = m_status;
  endtask

  task automatic step(input logic r, input logic w, input logic [15:0] i,
                      input logic [15:0] d, input logic [3:0] s, input logic [3:0] a);
    logic [3:0]  e_irq;
    logic [15:0] e_st;
    reset = r; bus.write = w; bus.id = i; bus.din = d; bus.irq_src = s; bus.irq_ack = a;
    model_step(r, w, i, d, s, a, e_irq, e_st);
    exp_q.push_back('{irq: e_irq, st: e_st});
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic [3:0] s);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 16'h0, s, 4'h0);
  endtask

  task automatic wr(input logic [15:0] i, input logic [15:0] d);
    step(1'b0, 1'b1, i, d, 4'h0, 4'h0);
  endtask

  task automatic ack(input logic [3:0] a, input logic [3:0] s);
    step(1'b0, 1'b0, 16'h0, 16'h0, s, a);
  endtask

  // Monitor: every cycle the DUT presents registered outputs; compare against the queue head
  initial begin
    exp_t e;
    int   cyc;
    cyc = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        n_cmp++;
        if (bus.irq_out !== e.irq) begin
          n_bad++;
          $display("FAIL irq_out cycle %0d: got %b, expected %b", cyc, bus.irq_out, e.irq);
        end
        n_cmp++;
        if (bus.status !== e.st) begin
          n_bad++;
          $display("FAIL status cycle %0d: got %h, expected %h", cyc, bus.status, e.st);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  src_r, a;
    logic [15:0] i;
    model_reset();
    reset = 1'b1; bus.write = 1'b0; bus.id = 16'h0; bus.din = 16'h0;
    bus.irq_src = 4'h0; bus.irq_ack = 4'h0;
    @(posedge clk);
    #2;

    // Reset state, single edge event, ack retire
    step(1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
    step(1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
    wr(MASK_ID, 16'h0001);
    idle(1, 4'b0001);
    idle(5, 4'h0);
    ack(4'b0001, 4'h0);
    idle(3, 4'h0);

    // Two pending sources presented in priority order
    wr(MASK_ID, 16'hFFFF);
    idle(1, 4'b1010);
    idle(5, 4'h0);
    ack(4'b0010, 4'h0);
    idle(3, 4'h0);
    ack(4'b1000, 4'h0);
    idle(3, 4'h0);

    // Mask removal aborts presentation, pending survives
    wr(MASK_ID, 16'h0004);
    idle(1, 4'b0100);
    idle(5, 4'h0);
    wr(MASK_ID, 16'h0000);
    idle(4, 4'h0);
    wr(PEND_ID, 16'h0004);
    idle(2, 4'h0);

    // New edge coinciding with its own ack keeps pending set
    wr(MASK_ID, 16'h0001);
    idle(1, 4'b0001);
    idle(5, 4'h0);
    idle(1, 4'b0001);
    idle(1, 4'h0);
    ack(4'b0001, 4'h0);
    idle(6, 4'h0);
    ack(4'b0001, 4'h0);
    idle(4, 4'h0);

    // Level-mode source held high re-pends after each ack
    wr(CFG_ID, 16'h000E);
    idle(6, 4'b0001);
    ack(4'b0001, 4'b0001);
    idle(4, 4'b0001);
    ack(4'b0001, 4'b0001);
    idle(4, 4'b0001);
    idle(4, 4'h0);
    ack(4'b0001, 4'h0);
    idle(4, 4'h0);
    wr(CFG_ID, 16'h000F);

    // Reset while active, then a write to an unused id
    wr(MASK_ID, 16'h0003);
    idle(1, 4'b0011);
    idle(6, 4'h0);
    step(1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 4'h0);
    wr(16'h0033, 16'hFFFF);
    idle(3, 4'h0);

    // Randomised traffic
    src_r = 4'h0;
    for (int n = 0; n < 2000; n++) begin
      src_r = src_r ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      a = 4'h0;
      if (m_pres >= 0 && $urandom_range(0, 2) == 0) a = 4'b0001 << m_pres;
      if ($urandom_range(0, 3) == 0) a = a | 4'($urandom);
      case ($urandom_range(0, 4))
        0:       i = MASK_ID;
        1:       i = PEND_ID;
        2:       i = CFG_ID;
        3:       i = 16'h0033;
        default: i = 16'($urandom);
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, i,
           16'($urandom), src_r, a);
    end

    idle(2, 4'h0);
    done = 1'b1;
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
